input_stream_fifo: RTL and testbench

Parametrised circular-buffer input FIFO that replaces the status-vector FIFO at the front of the non-linear approximation engine. It has read/write pointers with an occupancy counter and fixed 1-cycle registered read latency. It adds a valid strobe, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous clear. It keeps the start-sentinel detection: a configurable sentinel word is flagged and, optionally, not stored.

---
 rtl/input_stream_fifo.sv | 128 ++++++++++++
 tb/tb_input_stream_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_stream_fifo.sv
// input_stream_fifo: circular-buffer input FIFO for the front of the
// non-linear approximation engine. Read/write pointers plus an occupancy
// counter, 1-cycle registered read data with a valid strobe, programmable
// almost-full/almost-empty flags, sticky overflow/underflow and a
// synchronous clear. A configurable sentinel word marks stream start; it is
// always flagged on start_o and, when DROP_START is set, not stored.
//
// Handshake: wr_en and rd_en are requests, not guaranteed transfers.
// A write is accepted when it is storable and the FIFO is not full; a read
// is accepted when the FIFO is not empty. There is no fall-through: a write
// in the same cycle never satisfies a read from empty. valid_o is high for
// exactly one cycle after each accepted read, with data_o holding that word;
// otherwise data_o keeps its last value. Rejected requests only raise the
// sticky error flags.
module input_stream_fifo #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_LINES    = 4,
  parameter logic [DATA_WIDTH-1:0] START_WORD    = 32'h7F90_0000,
  parameter bit                    DROP_START    = 1'b1,
  parameter int                    AFULL_THRESH  = (1 << ADDR_LINES) - 2,
  parameter int                    AEMPTY_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_LINES:0]   count_o,
  output logic                  start_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << ADDR_LINES;
  localparam int CW    = ADDR_LINES + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  // Threshold ordering must leave room for both almost flags to be meaningful.
  if (AEMPTY_THRESH < 1 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH) begin : g_param_check
    $error("input_stream_fifo: need 1 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_LINES-1:0] wr_ptr;
  logic [ADDR_LINES-1:0] rd_ptr;
  logic [CW-1:0]         count_q;

  logic is_start;
  logic store_req;
  logic wr_acc;
  logic rd_acc;

  // Request decode: sentinel detection, storability and acceptance.
  assign is_start  = wr_en & (data_i == START_WORD);
  assign store_req = wr_en & ~(is_start & DROP_START);
  assign wr_acc    = store_req & ~full_o;
  assign rd_acc    = rd_en & ~empty_o;

  // Status flags decode the registered count only.
  assign count_o        = count_q;
  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AFULL_C);
  assign almost_empty_o = (count_q <= AEMPTY_C);

  // Storage write port; left unreset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !clr_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers, occupancy, registered read port and status/error flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      start_o     <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      start_o     <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        data_o <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      valid_o <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
      start_o <= is_start;
      if (store_req && full_o) begin
        overflow_o <= 1'b1;
      end
      if (rd_en && empty_o) begin
        underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_stream_fifo.sv
// Bench for input_stream_fifo (DEPTH = 16). A table of per-cycle vectors
// covers fill, overflow, drain and underflow; hand-written sequences cover
// clear priority, pointer wrap under continuous traffic, sentinel handling
// with and without dropping, and asynchronous reset mid-read.
module tb_input_stream_fifo;

  localparam int          DW = 32;
  localparam int          AL = 4;
  localparam logic [31:0] SW = 32'h7F90_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          clr, wr_en, rd_en;
  logic [DW-1:0] data_i;

  logic [DW-1:0] data_o;
  logic          valid_o, full_o, empty_o, af_o, ae_o, start_o, ovf_o, udf_o;
  logic [AL:0]   count_o;

  logic [DW-1:0] d0_data_o;
  logic          d0_valid_o, d0_full_o, d0_empty_o, d0_af_o, d0_ae_o;
  logic          d0_start_o, d0_ovf_o, d0_udf_o;
  logic [AL:0]   d0_count_o;

  input_stream_fifo #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .START_WORD(SW), .DROP_START(1'b1)) dut (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .wr_en(wr_en), .data_i(data_i), .rd_en(rd_en),
    .data_o(data_o), .valid_o(valid_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(af_o), .almost_empty_o(ae_o), .count_o(count_o), .start_o(start_o),
    .overflow_o(ovf_o), .underflow_o(udf_o)
  );

  input_stream_fifo #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .START_WORD(SW), .DROP_START(1'b0)) dut_keep (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .wr_en(wr_en), .data_i(data_i), .rd_en(rd_en),
    .data_o(d0_data_o), .valid_o(d0_valid_o), .full_o(d0_full_o), .empty_o(d0_empty_o),
    .almost_full_o(d0_af_o), .almost_empty_o(d0_ae_o), .count_o(d0_count_o), .start_o(d0_start_o),
    .overflow_o(d0_ovf_o), .underflow_o(d0_udf_o)
  );

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic [4:0]  count;
    logic        valid;
    logic [31:0] data;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic [31:0] d, input logic r, input logic c);
    wr_en  = w;
    data_i = d;
    rd_en  = r;
    clr    = c;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " count"}, 32'(count_o), 32'h0);
    chk({tag, " empty"}, 32'(empty_o), 32'h1);
    chk({tag, " full"},  32'(full_o),  32'h0);
    chk({tag, " ae"},    32'(ae_o),    32'h1);
    chk({tag, " af"},    32'(af_o),    32'h0);
    chk({tag, " data"},  data_o,       32'h0);
    chk({tag, " valid"}, 32'(valid_o), 32'h0);
    chk({tag, " start"}, 32'(start_o), 32'h0);
    chk({tag, " ovf"},   32'(ovf_o),   32'h0);
    chk({tag, " udf"},   32'(udf_o),   32'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] w;
    logic [31:0] e;

    // Vector table: 16 writes, one overflow write, 16 reads, one underflow read.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{wr: 1'b1, din: 32'(i + 1), rd: 1'b0, count: 5'(i + 1), valid: 1'b0,
                  data: 32'h0, full: (i == 15), empty: 1'b0, af: (i + 1 >= 14),
                  ae: (i + 1 <= 2), ovf: 1'b0, udf: 1'b0};
    end
    vecs[16] = '{wr: 1'b1, din: 32'h11, rd: 1'b0, count: 5'd16, valid: 1'b0, data: 32'h0,
                 full: 1'b1, empty: 1'b0, af: 1'b1, ae: 1'b0, ovf: 1'b1, udf: 1'b0};
    for (int k = 0; k < 16; k++) begin
      vecs[17 + k] = '{wr: 1'b0, din: 32'h0, rd: 1'b1, count: 5'(15 - k), valid: 1'b1,
                       data: 32'(k + 1), full: 1'b0, empty: (k == 15), af: (15 - k >= 14),
                       ae: (15 - k <= 2), ovf: 1'b1, udf: 1'b0};
    end
    vecs[33] = '{wr: 1'b0, din: 32'h0, rd: 1'b1, count: 5'd0, valid: 1'b0, data: 32'h10,
                 full: 1'b0, empty: 1'b1, af: 1'b0, ae: 1'b1, ovf: 1'b1, udf: 1'b1};

    // Reset
    rstn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_reset_state("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven fill / overflow / drain / underflow
    for (int i = 0; i < 34; i++) begin
      drive(vecs[i].wr, vecs[i].din, vecs[i].rd, 1'b0);
      cycle();
      chk($sformatf("v%0d count", i), 32'(count_o), 32'(vecs[i].count));
      chk($sformatf("v%0d valid", i), 32'(valid_o), 32'(vecs[i].valid));
      chk($sformatf("v%0d data", i),  data_o,       vecs[i].data);
      chk($sformatf("v%0d full", i),  32'(full_o),  32'(vecs[i].full));
      chk($sformatf("v%0d empty", i), 32'(empty_o), 32'(vecs[i].empty));
      chk($sformatf("v%0d af", i),    32'(af_o),    32'(vecs[i].af));
      chk($sformatf("v%0d ae", i),    32'(ae_o),    32'(vecs[i].ae));
      chk($sformatf("v%0d ovf", i),   32'(ovf_o),   32'(vecs[i].ovf));
      chk($sformatf("v%0d udf", i),   32'(udf_o),   32'(vecs[i].udf));
    end

    // Clear priority: reach count 7 with overflow set, then clr with wr/rd
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("pre_clr count", 32'(count_o), 32'd7);
    chk("pre_clr ovf",   32'(ovf_o),   32'h1);
    drive(1'b1, 32'hABCD, 1'b1, 1'b1);
    cycle();
    check_reset_state("clr");
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("post_clr count", 32'(count_o), 32'h0);

    // Continuous read/write at count 5 across pointer wrap
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      w = 32'h1000_0000 + 32'(i);
      drive(1'b1, w, 1'b0, 1'b0);
      cycle();
      exp_q.push_back(w);
    end
    chk("prime count", 32'(count_o), 32'd5);
    for (int c = 0; c < 40; c++) begin
      w = 32'h2000_0000 + 32'(c);
      drive(1'b1, w, 1'b1, 1'b0);
      cycle();
      e = exp_q.pop_front();
      exp_q.push_back(w);
      chk($sformatf("wrap%0d data", c),  data_o,       e);
      chk($sformatf("wrap%0d valid", c), 32'(valid_o), 32'h1);
      chk($sformatf("wrap%0d count", c), 32'(count_o), 32'd5);
    end
    chk("wrap ovf",  32'(ovf_o),  32'h0);
    chk("wrap udf",  32'(udf_o),  32'h0);
    chk("wrap full", 32'(full_o), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
      e = exp_q.pop_front();
      chk($sformatf("drain%0d data", i), data_o, e);
    end
    chk("drain empty", 32'(empty_o), 32'h1);

    // Sentinel: dropped by dut, stored by dut_keep
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000_0001 + 32'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, SW, 1'b0, 1'b0);
    cycle();
    chk("sent start",       32'(start_o),    32'h1);
    chk("sent count",       32'(count_o),    32'd3);
    chk("sent keep start",  32'(d0_start_o), 32'h1);
    chk("sent keep count",  32'(d0_count_o), 32'd4);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("sent start off",      32'(start_o),    32'h0);
    chk("sent keep start off", 32'(d0_start_o), 32'h0);

    // Sentinel while full must not raise overflow when it is dropped
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
      cycle();
    end
    chk("full again", 32'(full_o), 32'h1);
    drive(1'b1, SW, 1'b0, 1'b0);
    cycle();
    chk("full sent start", 32'(start_o), 32'h1);
    chk("full sent ovf",   32'(ovf_o),   32'h0);
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    cycle();
    chk("full write ovf", 32'(ovf_o), 32'h1);

    // Asynchronous reset mid-read
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("pre_rst data",  data_o,       32'h3000_0001);
    chk("pre_rst valid", 32'(valid_o), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    chk("rst rd udf",   32'(udf_o),   32'h1);
    chk("rst rd valid", 32'(valid_o), 32'h0);
    chk("rst rd count", 32'(count_o), 32'h0);

    drive(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
